logo_motion_ctrl: RTL and testbench

Frame-rate scheduler that animates the bitmap logo across the 640x480 VGA raster. It sits between `vga_sync_generator` and the bitmap ROM/palette datapath. Once per frame it advances the logo origin, bounces it off the screen edges, counts bounces, and rotates a palette offset on each bounce. Per pixel it produces a registered logo-window hit plus the ROM-local x/y coordinates.

---
 rtl/logo_motion_ctrl_pkg.sv | 13 +
 rtl/logo_motion_ctrl_axis_bounce.sv | 44 ++++
 rtl/logo_motion_ctrl.sv | 136 +++++++++++++
 tb/tb_logo_motion_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/logo_motion_ctrl_pkg.sv
// Shared VGA raster constants and the logo-motion FSM state encoding.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        UPDATE = 2'd2
    } motion_state_t;

endpackage

// File: rtl/logo_motion_ctrl_axis_bounce.sv
// One axis of logo motion: step the origin and reflect it at 0 and MAX.
module axis_bounce #(
    parameter int unsigned STEP = 2,
    parameter int unsigned MAX  = 624
) (
    input  logic [9:0] pos,
    input  logic       dir,
    output logic [9:0] next_pos,
    output logic       next_dir,
    output logic       bounce
);

    logic [10:0] pos_ext;
    logic [10:0] sum;
    logic [10:0] diff;

    always_comb begin
        pos_ext  = {1'b0, pos};
        sum      = pos_ext + 11'(STEP);
        diff     = pos_ext - 11'(STEP);
        next_pos = pos;
        next_dir = dir;
        bounce   = 1'b0;
        if (!dir) begin
            if (sum >= 11'(MAX)) begin
                next_pos = 10'(MAX);
                next_dir = 1'b1;
                bounce   = 1'b1;
            end else begin
                next_pos = sum[9:0];
            end
        end else begin
            // The compare guards the subtraction, so diff never wraps when used.
            if (pos_ext <= 11'(STEP)) begin
                next_pos = '0;
                next_dir = 1'b0;
                bounce   = 1'b1;
            end else begin
                next_pos = diff[9:0];
            end
        end
    end

endmodule

// File: rtl/logo_motion_ctrl.sv
// Per-frame bouncing-logo scheduler plus registered per-pixel logo-window lookup.
module logo_motion_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int unsigned LOGO_W   = 16,
    parameter int unsigned LOGO_H   = 128,
    parameter int unsigned STEP     = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        frame_tick,
    input  logic                        display_on,
    input  logic [9:0]                  hpos,
    input  logic [9:0]                  vpos,
    output logic [9:0]                  logo_x,
    output logic [9:0]                  logo_y,
    output logic                        dir_x,
    output logic                        dir_y,
    output logic [7:0]                  bounce_cnt,
    output logic [2:0]                  pal_rot,
    output logic                        corner_hit,
    output logic                        in_logo,
    output logic [$clog2(LOGO_W)-1:0]   lx,
    output logic [$clog2(LOGO_H)-1:0]   ly
);

    localparam int unsigned XMAX = H_ACTIVE - LOGO_W;
    localparam int unsigned YMAX = V_ACTIVE - LOGO_H;
    localparam int unsigned LXW  = $clog2(LOGO_W);
    localparam int unsigned LYW  = $clog2(LOGO_H);

    motion_state_t state;
    motion_state_t state_next;
    logic          do_update;

    logic [9:0] next_x;
    logic [9:0] next_y;
    logic       next_dir_x;
    logic       next_dir_y;
    logic       bounce_x;
    logic       bounce_y;

    axis_bounce #(.STEP(STEP), .MAX(XMAX)) u_axis_x (
        .pos      (logo_x),
        .dir      (dir_x),
        .next_pos (next_x),
        .next_dir (next_dir_x),
        .bounce   (bounce_x)
    );

    axis_bounce #(.STEP(STEP), .MAX(YMAX)) u_axis_y (
        .pos      (logo_y),
        .dir      (dir_y),
        .next_pos (next_y),
        .next_dir (next_dir_y),
        .bounce   (bounce_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = WAIT;
            WAIT: begin
                if (!enable)         state_next = IDLE;
                else if (frame_tick) state_next = UPDATE;
            end
            UPDATE:  state_next = enable ? WAIT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        do_update = (state == UPDATE);
    end

    // The update commits even when enable drops during UPDATE; only reset discards it.
    always_ff @(posedge clk) begin
        if (reset) begin
            logo_x     <= '0;
            logo_y     <= '0;
            dir_x      <= 1'b0;
            dir_y      <= 1'b0;
            bounce_cnt <= '0;
            pal_rot    <= '0;
            corner_hit <= 1'b0;
        end else begin
            corner_hit <= do_update && bounce_x && bounce_y;
            if (do_update) begin
                logo_x <= next_x;
                logo_y <= next_y;
                dir_x  <= next_dir_x;
                dir_y  <= next_dir_y;
                if (bounce_x || bounce_y) begin
                    bounce_cnt <= bounce_cnt + 8'd1;
                    pal_rot    <= pal_rot + 3'd1;
                end
            end
        end
    end

    logic [10:0] x_end;
    logic [10:0] y_end;
    logic        hit;

    always_comb begin
        x_end = {1'b0, logo_x} + 11'(LOGO_W);
        y_end = {1'b0, logo_y} + 11'(LOGO_H);
        hit   = display_on
              && (hpos >= logo_x) && ({1'b0, hpos} < x_end)
              && (vpos >= logo_y) && ({1'b0, vpos} < y_end);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_logo <= 1'b0;
            lx      <= '0;
            ly      <= '0;
        end else begin
            in_logo <= hit;
            lx      <= LXW'(hpos - logo_x);
            ly      <= LYW'(vpos - logo_y);
        end
    end

endmodule

// File: tb/tb_logo_motion_ctrl.sv
// Directed bench for logo_motion_ctrl: motion, bounces, corner, enable gating, pixel window, reset.
module tb_logo_motion_ctrl;
    import vga_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       frame_tick;
    logic       display_on;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic [9:0] logo_x;
    logic [9:0] logo_y;
    logic       dir_x;
    logic       dir_y;
    logic [7:0] bounce_cnt;
    logic [2:0] pal_rot;
    logic       corner_hit;
    logic       in_logo;
    logic [3:0] lx;
    logic [6:0] ly;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned tick_n   = 0;
    int unsigned corner_cnt = 0;

    always #5 clk = ~clk;

    logo_motion_ctrl #(
        .H_ACTIVE (640),
        .V_ACTIVE (480),
        .LOGO_W   (16),
        .LOGO_H   (128),
        .STEP     (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .frame_tick (frame_tick),
        .display_on (display_on),
        .hpos       (hpos),
        .vpos       (vpos),
        .logo_x     (logo_x),
        .logo_y     (logo_y),
        .dir_x      (dir_x),
        .dir_y      (dir_y),
        .bounce_cnt (bounce_cnt),
        .pal_rot    (pal_rot),
        .corner_hit (corner_hit),
        .in_logo    (in_logo),
        .lx         (lx),
        .ly         (ly)
    );

    always @(negedge clk) begin
        if (corner_hit === 1'b1) corner_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Tick is sampled at the next posedge; results are settled when this returns.
    task automatic do_tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        @(negedge clk);
        tick_n++;
    endtask

    task automatic run_to(input int unsigned target);
        while (tick_n < target) do_tick();
    endtask

    task automatic check_pos(input string tag, input int unsigned x, input int unsigned y,
                             input int unsigned dx, input int unsigned dy);
        check_eq({tag, ".x"}, 32'(logo_x), x);
        check_eq({tag, ".y"}, 32'(logo_y), y);
        check_eq({tag, ".dir_x"}, 32'(dir_x), dx);
        check_eq({tag, ".dir_y"}, 32'(dir_y), dy);
    endtask

    task automatic check_reset_state(input string tag);
        check_pos(tag, 0, 0, 0, 0);
        check_eq({tag, ".bounce_cnt"}, 32'(bounce_cnt), 0);
        check_eq({tag, ".pal_rot"}, 32'(pal_rot), 0);
        check_eq({tag, ".corner_hit"}, 32'(corner_hit), 0);
        check_eq({tag, ".in_logo"}, 32'(in_logo), 0);
        check_eq({tag, ".lx"}, 32'(lx), 0);
        check_eq({tag, ".ly"}, 32'(ly), 0);
        check_eq({tag, ".state"}, 32'(dut.state), 32'(IDLE));
    endtask

    task automatic pix(input string tag, input int unsigned h, input int unsigned v, input logic d,
                       input logic exp_in, input int unsigned exp_lx, input int unsigned exp_ly);
        @(negedge clk);
        hpos = 10'(h);
        vpos = 10'(v);
        display_on = d;
        @(negedge clk);
        check_eq({tag, ".in_logo"}, 32'(in_logo), 32'(exp_in));
        if (exp_in) begin
            check_eq({tag, ".lx"}, 32'(lx), exp_lx);
            check_eq({tag, ".ly"}, 32'(ly), exp_ly);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got tick %0d, expected completion", tick_n);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        frame_tick = 1'b0;
        display_on = 1'b0;
        hpos = '0;
        vpos = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");

        reset = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        check_eq("idle_to_wait", 32'(dut.state), 32'(WAIT));

        do_tick();
        check_pos("tick1", 2, 2, 0, 0);
        do_tick();
        check_pos("tick2", 4, 4, 0, 0);
        check_eq("tick2.bounce_cnt", 32'(bounce_cnt), 0);

        run_to(50);
        check_pos("tick50", 100, 100, 0, 0);
        pix("pix_origin", 100, 100, 1'b1, 1'b1, 0, 0);
        pix("pix_far",    115, 227, 1'b1, 1'b1, 15, 127);
        pix("pix_mid",    107, 150, 1'b1, 1'b1, 7, 50);
        pix("pix_right",  116, 100, 1'b1, 1'b0, 0, 0);
        pix("pix_below",  100, 228, 1'b1, 1'b0, 0, 0);
        pix("pix_left",    99, 100, 1'b1, 1'b0, 0, 0);
        pix("pix_above",  100,  99, 1'b1, 1'b0, 0, 0);
        pix("pix_blank",  107, 150, 1'b0, 1'b0, 0, 0);

        run_to(176);
        check_pos("ybounce", 352, 352, 0, 1);
        check_eq("ybounce.bounce_cnt", 32'(bounce_cnt), 1);
        check_eq("ybounce.pal_rot", 32'(pal_rot), 1);
        do_tick();
        check_pos("ybounce_next", 354, 350, 0, 1);

        run_to(312);
        check_pos("xbounce", 624, 80, 1, 1);
        check_eq("xbounce.bounce_cnt", 32'(bounce_cnt), 2);
        check_eq("xbounce.pal_rot", 32'(pal_rot), 2);
        do_tick();
        check_pos("xbounce_next", 622, 78, 1, 1);

        // X period 312 ticks, Y period 176 ticks: both axes first bounce together on tick 6864.
        run_to(6863);
        check_pos("pre_corner", 2, 350, 1, 0);
        check_eq("pre_corner.bounce_cnt", 32'(bounce_cnt), 59);
        check_eq("pre_corner.corner_cnt", corner_cnt, 0);
        do_tick();
        check_pos("corner", 0, 352, 0, 1);
        check_eq("corner.bounce_cnt", 32'(bounce_cnt), 60);
        check_eq("corner.pal_rot", 32'(pal_rot), 4);
        check_eq("corner.pulse", 32'(corner_hit), 1);
        @(negedge clk);
        check_eq("corner.pulse_end", 32'(corner_hit), 0);

        @(negedge clk) enable = 1'b0;
        repeat (10) do_tick();
        check_pos("frozen", 0, 352, 0, 1);
        check_eq("frozen.state", 32'(dut.state), 32'(IDLE));
        check_eq("frozen.bounce_cnt", 32'(bounce_cnt), 60);

        @(negedge clk);
        enable = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check_eq("enable_tick.state", 32'(dut.state), 32'(WAIT));
        repeat (2) @(negedge clk);
        check_pos("enable_tick_ignored", 0, 352, 0, 1);
        do_tick();
        check_pos("resume", 2, 350, 0, 1);
        check_eq("corner_total", corner_cnt, 1);

        pix("pre_reset_pix", 5, 400, 1'b1, 1'b1, 3, 50);
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        reset = 1'b1;
        check_eq("mid_update.state", 32'(dut.state), 32'(UPDATE));
        @(negedge clk);
        check_reset_state("reset_in_update");
        reset = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
